calc_result_display: RTL and testbench

//  Downstream consumer of the calculator's sequential divider result (quotient/remainder/err/ready).

---
 rtl/calc_result_display_pkg.sv | 35 +++
 rtl/calc_result_display_seg7_decode.sv | 15 +
 rtl/calc_result_display.sv | 173 +++++++++++++++++
 tb/tb_calc_result_display.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_result_display_pkg.sv
// Shared definitions for the calculator result display: FSM encoding,
// special segment glyphs and the decimal digit segment table.
package calc_result_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;

  // Decimal digit to segments; anything above 9 renders blank
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/calc_result_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with blank override.
module calc_result_display_seg7_decode
  import calc_result_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the digit value
  always_comb begin
    seg = blank ? SEG_BLANK : digit_seg(digit);
  end

endmodule

// File: rtl/calc_result_display.sv
// Captures divider results, converts them to BCD with a sequential
// double-dabble and scans them onto a 4-digit common-anode display.
module calc_result_display
  import calc_result_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             res_ready,
  input  logic [WIDTH-1:0] res_quot,
  input  logic [WIDTH-1:0] res_rem,
  input  logic             res_err,
  input  logic             sel_rem,
  output logic             busy,
  output logic [15:0]      bcd,
  output logic [6:0]       seg,
  output logic [3:0]       an
);

  localparam int BW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  // Double-dabble correction: add 3 to every nibble that is 5 or more
  function automatic logic [15:0] dd_adjust(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
    end
    return r;
  endfunction

  logic             ready_q, sel_q;
  logic [WIDTH-1:0] quot_l, rem_l;
  logic             err_l;
  state_t           state;
  logic [BW-1:0]    bit_cnt;
  logic [15:0]      scratch;
  logic [WIDTH-1:0] operand;
  logic             err_disp;
  logic [CW-1:0]    scan_cnt;
  logic [1:0]       idx;

  logic             ready_edge, sel_chg, trig;
  logic [WIDTH-1:0] cur_quot, cur_rem, next_operand;
  logic             cur_err;
  logic [15:0]      adj;
  logic [3:0]       nz;
  logic [3:0]       digit;
  logic             blank;
  logic [6:0]       dec_seg, seg_nxt;

  // Trigger detection; a sel-only change reuses the previously latched result
  always_comb begin
    ready_edge   = res_ready & ~ready_q;
    sel_chg      = sel_rem ^ sel_q;
    trig         = ready_edge | sel_chg;
    cur_quot     = ready_edge ? res_quot : quot_l;
    cur_rem      = ready_edge ? res_rem  : rem_l;
    cur_err      = ready_edge ? res_err  : err_l;
    next_operand = sel_rem ? cur_rem : cur_quot;
    adj          = dd_adjust(scratch);
  end

  // Control: edge-detect history, conversion FSM and published result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q  <= 1'b0;
      sel_q    <= 1'b0;
      state    <= ST_IDLE;
      busy     <= 1'b0;
      bcd      <= 16'h0000;
      err_disp <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      ready_q <= res_ready;
      sel_q   <= sel_rem;
      if (trig) begin
        if (cur_err) begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          err_disp <= 1'b1;
        end else begin
          state   <= ST_SHIFT;
          busy    <= 1'b1;
          bit_cnt <= '0;
        end
      end else begin
        case (state)
          ST_SHIFT: begin
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) state <= ST_DONE;
          end
          ST_DONE: begin
            bcd      <= scratch;
            err_disp <= 1'b0;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Datapath: latched result and shift-add-3 scratch/operand registers
  always_ff @(posedge clk) begin
    if (trig) begin
      quot_l  <= cur_quot;
      rem_l   <= cur_rem;
      err_l   <= cur_err;
      scratch <= 16'h0000;
      operand <= next_operand;
    end else if (state == ST_SHIFT) begin
      scratch <= (adj << 1) | {15'd0, operand[WIDTH-1]};
      operand <= operand << 1;
    end
  end

  // Leading-zero blanking: a digit is blank when it and all digits above are zero
  always_comb begin
    nz = 4'b0000;
    for (int k = 0; k < 4; k++) nz[k] = |bcd[4*k +: 4];
    digit = bcd[{idx, 2'b00} +: 4];
    case (idx)
      2'd0:    blank = 1'b0;
      2'd1:    blank = ~|nz[3:1];
      2'd2:    blank = ~|nz[3:2];
      default: blank = ~nz[3];
    endcase
  end

  calc_result_display_seg7_decode u_dec (
    .digit (digit),
    .blank (blank),
    .seg   (dec_seg)
  );

  // Error message " Err" overrides the numeric digits
  always_comb begin
    seg_nxt = dec_seg;
    if (err_disp) begin
      case (idx)
        2'd3:    seg_nxt = SEG_BLANK;
        2'd2:    seg_nxt = SEG_E;
        default: seg_nxt = SEG_R;
      endcase
    end
  end

  // Scan timer, digit index and registered anode/segment drive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= 4'hF;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_calc_result_display.sv
// Bench for calc_result_display with WIDTH=8, SCAN_DIV=4.
module tb_calc_result_display;

  localparam int WIDTH    = 8;
  localparam int SCAN_DIV = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             res_ready;
  logic [WIDTH-1:0] res_quot;
  logic [WIDTH-1:0] res_rem;
  logic             res_err;
  logic             sel_rem;
  logic             busy;
  logic [15:0]      bcd;
  logic [6:0]       seg;
  logic [3:0]       an;

  int n_vec  = 0;
  int n_miss = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [15:0]      exp_bcd;
    logic [6:0]       s0, s1, s2, s3;
  } vec_t;

  vec_t vecs[6];

  calc_result_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .res_ready (res_ready),
    .res_quot  (res_quot),
    .res_rem   (res_rem),
    .res_err   (res_err),
    .sel_rem   (sel_rem),
    .busy      (busy),
    .bcd       (bcd),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk(name, {16'd0, bcd}, {16'd0, e});
    end
  endtask

  // Watch one full scan period and check every lit digit's segments
  task automatic scan_check(input string name, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] e;
    for (int c = 0; c < 4 * SCAN_DIV; c++) begin
      tick();
      case (an)
        4'hE: e = e0;
        4'hD: e = e1;
        4'hB: e = e2;
        4'h7: e = e3;
        default: e = 7'h55;
      endcase
      if (e == 7'h55) chk({name, "_an"}, {28'd0, an}, 32'hE);
      else chk({name, "_seg"}, {25'd0, seg}, {25'd0, e});
    end
  endtask

  // Conversion already triggered by the caller; measure busy and check result
  task automatic run_conv(input string name, input logic [6:0] e0, input logic [6:0] e1,
                          input logic [6:0] e2, input logic [6:0] e3);
    int cnt;
    tick();
    res_ready = 1'b0;
    chk({name, "_busy_rise"}, {31'd0, busy}, 32'd1);
    cnt = busy ? 1 : 0;
    for (int g = 0; g < 60; g++) begin
      if (!busy) break;
      tick();
      if (busy) cnt++;
    end
    chk({name, "_busy_len"}, cnt, WIDTH + 1);
    sb_check({name, "_bcd"});
    tick();
    scan_check(name, e0, e1, e2, e3);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{quot: 8'd4,   rem: 8'd0, exp_bcd: 16'h0004, s0: 7'h19, s1: 7'h7F, s2: 7'h7F, s3: 7'h7F};
    vecs[1] = '{quot: 8'd0,   rem: 8'd9, exp_bcd: 16'h0000, s0: 7'h40, s1: 7'h7F, s2: 7'h7F, s3: 7'h7F};
    vecs[2] = '{quot: 8'd200, rem: 8'd1, exp_bcd: 16'h0200, s0: 7'h40, s1: 7'h40, s2: 7'h24, s3: 7'h7F};
    vecs[3] = '{quot: 8'd109, rem: 8'd5, exp_bcd: 16'h0109, s0: 7'h10, s1: 7'h40, s2: 7'h79, s3: 7'h7F};
    vecs[4] = '{quot: 8'd87,  rem: 8'd2, exp_bcd: 16'h0087, s0: 7'h78, s1: 7'h00, s2: 7'h7F, s3: 7'h7F};
    vecs[5] = '{quot: 8'd255, rem: 8'd3, exp_bcd: 16'h0255, s0: 7'h12, s1: 7'h12, s2: 7'h24, s3: 7'h7F};

    reset = 1'b0; res_ready = 1'b0; res_quot = '0; res_rem = '0; res_err = 1'b0; sel_rem = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bcd", {16'd0, bcd}, 32'd0);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {28'd0, an}, 32'hF);
    reset = 1'b1;
    tick();
    chk("post_rst_an", {28'd0, an}, 32'hE);
    chk("post_rst_seg", {25'd0, seg}, 32'h40);

    // Table of ready-edge conversions showing the quotient
    foreach (vecs[i]) begin
      res_quot = vecs[i].quot;
      res_rem = vecs[i].rem;
      res_ready = 1'b1;
      sb_q.push_back(vecs[i].exp_bcd);
      run_conv($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3);
    end

    // sel change alone reconverts the latched remainder, then the quotient
    res_quot = 8'd42; res_rem = 8'd99;
    sel_rem = 1'b1;
    sb_q.push_back(16'h0003);
    run_conv("sel_rem", 7'h30, 7'h7F, 7'h7F, 7'h7F);
    sel_rem = 1'b0;
    sb_q.push_back(16'h0255);
    run_conv("sel_quot", 7'h12, 7'h12, 7'h24, 7'h7F);

    // Divide error: no conversion, " Err" shown, bcd kept
    res_err = 1'b1; res_quot = 8'd11; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (busy) cnt++;
      tick();
    end
    chk("err_busy_cycles", cnt, 0);
    chk("err_bcd_kept", {16'd0, bcd}, 32'h0255);
    scan_check("err", 7'h2F, 7'h2F, 7'h06, 7'h7F);
    res_err = 1'b0;

    // Restart mid-conversion: latest trigger wins, busy never drops
    res_quot = 8'd100; res_ready = 1'b1;
    sb_q.push_back(16'h0007);
    tick();
    res_ready = 1'b0;
    cnt = busy ? 1 : 0;
    repeat (3) begin
      tick();
      if (busy) cnt++;
    end
    res_quot = 8'd7; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    if (busy) cnt++;
    for (int g = 0; g < 60; g++) begin
      tick();
      if (busy) cnt++;
      else break;
    end
    chk("restart_busy_len", cnt, 4 + WIDTH + 1);
    sb_check("restart_bcd");
    tick();
    scan_check("restart", 7'h78, 7'h7F, 7'h7F, 7'h7F);

    // Asynchronous reset in the middle of a conversion
    res_quot = 8'd50; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick(); tick();
    chk("pre_arst_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_bcd", {16'd0, bcd}, 32'd0);
    chk("arst_seg", {25'd0, seg}, 32'h7F);
    chk("arst_an", {28'd0, an}, 32'hF);
    #2 reset = 1'b1;
    tick();
    chk("arst_rel_an", {28'd0, an}, 32'hE);
    chk("arst_rel_seg", {25'd0, seg}, 32'h40);
    chk("arst_rel_busy", {31'd0, busy}, 32'd0);
    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
